// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC APB register bank: register map, STATUS
// bit positions, controller mode encodings and the op sequencer state type.
package ecc_pkg;

    localparam int unsigned ADDR_CTRL     = 'h00;
    localparam int unsigned ADDR_DATA_IN  = 'h04;
    localparam int unsigned ADDR_CW       = 'h08;
    localparam int unsigned ADDR_NOISE    = 'h0C;
    localparam int unsigned ADDR_DATA_OUT = 'h10;
    localparam int unsigned ADDR_STATUS   = 'h14;
    localparam int unsigned ADDR_IRQ_CLR  = 'h18;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_NERR_LO  = 3;
    localparam int STAT_BAD_MODE = 5;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_FULL = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_START = 2'd1,
        OP_WAIT  = 2'd2
    } op_state_t;

endpackage

// File: rtl/ecc_op_sequencer.sv
// Operation sequencer: launches one controller operation, waits for its
// completion strobe and declares a timeout if none arrives in time.
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_launch,
    input  logic      i_operation_done,
    input  logic [1:0] i_mode,
    output logic      o_ctrl_ready,
    output logic      o_busy,
    output logic      o_capture,
    output logic      o_timeout_set,
    output op_state_t o_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    op_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ctrl_ready;
    logic             w_in_wait;

    assign w_in_wait     = (r_state == OP_WAIT);
    // Completion wins over a timeout landing on the same cycle.
    assign o_capture     = w_in_wait & i_operation_done;
    assign o_timeout_set = w_in_wait & ~i_operation_done &
                           (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_busy        = (r_state != OP_IDLE);
    assign o_ctrl_ready  = r_ctrl_ready;
    assign o_state       = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= OP_IDLE;
            r_cnt        <= '0;
            r_ctrl_ready <= 1'b0;
        end else begin
            case (r_state)
                OP_IDLE: begin
                    r_ctrl_ready <= 1'b0;
                    if (i_launch && (i_mode != MODE_BAD)) begin
                        r_state      <= OP_START;
                        r_ctrl_ready <= 1'b1;
                    end
                end
                OP_START: begin
                    r_ctrl_ready <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= OP_WAIT;
                end
                OP_WAIT: begin
                    r_ctrl_ready <= 1'b0;
                    if (o_capture || o_timeout_set) begin
                        r_state <= OP_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= OP_IDLE;
                    r_ctrl_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ecc_apb_regfile.sv
// APB3 register bank driving the ECC controller operands, launching
// operations via CTRL writes and collecting results with an interrupt.
module ecc_apb_regfile
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [AMBA_WORD-1:0]  PWDATA,
    output logic [AMBA_WORD-1:0]  PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [AMBA_WORD-1:0]  CTRL,
    output logic [AMBA_WORD-1:0]  DATA_IN,
    output logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
    output logic [AMBA_WORD-1:0]  NOISE,
    output logic                  CTRL_ready,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  operation_done,
    input  logic [1:0]            num_of_errors,
    output logic                  irq
);

    logic [AMBA_WORD-1:0]  r_ctrl, r_data_in, r_cw, r_noise;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [1:0]            r_nerr;
    logic                  r_done, r_timeout, r_bad_mode, r_irq;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic w_access, w_sel_ctrl, w_sel_data_in, w_sel_cw, w_sel_noise;
    logic w_sel_data_out, w_sel_status, w_sel_irq_clr;
    logic w_sel_operand, w_sel_ro, w_mapped, w_err, w_wr, w_protect;
    logic w_launch, w_busy, w_capture, w_timeout_set;
    logic w_done_nxt, w_timeout_nxt, w_unused;
    logic [AMBA_WORD-1:0] w_status, w_rdata;
    op_state_t w_op_state;

    assign w_unused = ^PADDR[1:0];
    assign w_access = PSEL & PENABLE;
    assign w_addr   = {PADDR[ADDR_WIDTH-1:2], 2'b00};

    assign w_sel_ctrl     = (w_addr == ADDR_WIDTH'(ADDR_CTRL));
    assign w_sel_data_in  = (w_addr == ADDR_WIDTH'(ADDR_DATA_IN));
    assign w_sel_cw       = (w_addr == ADDR_WIDTH'(ADDR_CW));
    assign w_sel_noise    = (w_addr == ADDR_WIDTH'(ADDR_NOISE));
    assign w_sel_data_out = (w_addr == ADDR_WIDTH'(ADDR_DATA_OUT));
    assign w_sel_status   = (w_addr == ADDR_WIDTH'(ADDR_STATUS));
    assign w_sel_irq_clr  = (w_addr == ADDR_WIDTH'(ADDR_IRQ_CLR));

    assign w_sel_operand = w_sel_ctrl | w_sel_data_in | w_sel_cw | w_sel_noise;
    assign w_sel_ro      = w_sel_data_out | w_sel_status;
    assign w_mapped      = w_sel_operand | w_sel_ro | w_sel_irq_clr;
    // Operands must stay frozen while the controller is using them.
    assign w_protect     = (w_op_state != OP_IDLE);

    assign w_err = ~w_mapped
                 | (PWRITE & w_sel_operand & w_protect)
                 | (PWRITE & w_sel_ro)
                 | (~PWRITE & w_sel_irq_clr);

    assign PREADY   = 1'b1;
    assign PSLVERR  = w_access & w_err;
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign w_launch = w_wr & w_sel_ctrl;

    ecc_op_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_seq (
        .clk             (clk),
        .reset           (reset),
        .i_launch        (w_launch),
        .i_operation_done(operation_done),
        .i_mode          (PWDATA[1:0]),
        .o_ctrl_ready    (CTRL_ready),
        .o_busy          (w_busy),
        .o_capture       (w_capture),
        .o_timeout_set   (w_timeout_set),
        .o_state         (w_op_state)
    );

    always_comb begin
        w_status                    = '0;
        w_status[STAT_BUSY]         = w_busy;
        w_status[STAT_DONE]         = r_done;
        w_status[STAT_TIMEOUT]      = r_timeout;
        w_status[STAT_NERR_LO+:2]   = r_nerr;
        w_status[STAT_BAD_MODE]     = r_bad_mode;
    end

    always_comb begin
        w_rdata = '0;
        if (w_access && !PWRITE && !w_err) begin
            if (w_sel_ctrl)     w_rdata = r_ctrl;
            if (w_sel_data_in)  w_rdata = r_data_in;
            if (w_sel_cw)       w_rdata = r_cw;
            if (w_sel_noise)    w_rdata = r_noise;
            if (w_sel_data_out) w_rdata = AMBA_WORD'(r_data_out);
            if (w_sel_status)   w_rdata = w_status;
        end
    end
    assign PRDATA = w_rdata;

    // Set beats clear when a completion lands alongside an IRQ_CLR write.
    always_comb begin
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        if (w_launch) begin
            w_done_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
        end
        if (w_wr && w_sel_irq_clr) begin
            if (PWDATA[STAT_DONE])    w_done_nxt    = 1'b0;
            if (PWDATA[STAT_TIMEOUT]) w_timeout_nxt = 1'b0;
        end
        if (w_capture)     w_done_nxt    = 1'b1;
        if (w_timeout_set) w_timeout_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_data_in  <= '0;
            r_cw       <= '0;
            r_noise    <= '0;
            r_data_out <= '0;
            r_nerr     <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_bad_mode <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_launch) begin
                r_ctrl     <= PWDATA;
                r_bad_mode <= (PWDATA[1:0] == MODE_BAD);
            end
            if (w_wr && w_sel_data_in) r_data_in <= PWDATA;
            if (w_wr && w_sel_cw)      r_cw      <= PWDATA;
            if (w_wr && w_sel_noise)   r_noise   <= PWDATA;
            if (w_capture) begin
                r_data_out <= data_out;
                r_nerr     <= (r_ctrl[1:0] == MODE_ENC) ? 2'b00 : num_of_errors;
            end
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_irq     <= w_done_nxt | w_timeout_nxt;
        end
    end

    assign CTRL           = r_ctrl;
    assign DATA_IN        = r_data_in;
    assign CODEWORD_WIDTH = r_cw;
    assign NOISE          = r_noise;
    assign irq            = r_irq;

endmodule
